mtx_sequencer: RTL

- Parametrised matrix-multiply (MMULT) sequencer for the GPU systolic multiply/accumulate path.
- Takes a decoded MMULT instruction and issues one operand-fetch per element from matrix RAM.
- Emits the per-cycle systolic instruction stream: first multiply, N-1 accumulates, then result write.
- Improves on the fixed-size predecessor: configurable width/address size, width-1 matrices, selectable row/column stride with wrap, explicit done pulse and data-wait reporting.

---
 rtl/mtx_sequencer.sv | 118 +++++++++++
 1 files changed

// File: rtl/mtx_sequencer.sv
// rtl/mtx_sequencer.sv - MMULT sequencer: per-element operand fetch and systolic MULT/MAC/RESULT issue
module mtx_sequencer #(
  parameter int AW = 10,
  parameter int CW = 4,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          advance,
  input  logic          start,
  input  logic [RW-1:0] src_reg,
  input  logic [RW-1:0] dst_reg,
  input  logic          cfg_wr,
  input  logic [CW:0]   cfg_din,
  input  logic          base_wr,
  input  logic [AW-1:0] base_din,
  input  logic          datack,
  output logic          mreq,
  output logic [AW-1:0] maddr,
  output logic          mwait,
  output logic          busy,
  output logic          atomic,
  output logic [1:0]    ins_op,
  output logic [RW-1:0] ins_src,
  output logic [RW-1:0] ins_dst,
  output logic          half,
  output logic          done
);

  // Encoding doubles as the ins_op code: IDLE=none, FIRST=MULT, MAC=MAC, RESULT=RESULT.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    FIRST  = 2'b01,
    MAC    = 2'b10,
    RESULT = 2'b11
  } state_t;

  state_t        state, state_next;
  logic [CW:0]   count;
  logic [CW:0]   step;
  logic [CW-1:0] width_reg;
  logic          col_reg;
  logic          pending;
  logic          done_next;
  logic [CW:0]   width_full;
  logic          accept;
  logic          in_products;

  // A zero width field means the full 2^CW elements.
  assign width_full  = {(width_reg == '0), width_reg};
  assign accept      = (state == IDLE) && start && advance;
  assign in_products = (state == FIRST) || (state == MAC);

  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    case (state)
      IDLE:   if (accept) state_next = FIRST;
      FIRST:  if (advance) state_next = (count == (CW+1)'(1)) ? RESULT : MAC;
      MAC:    if (advance && count == (CW+1)'(1)) state_next = RESULT;
      RESULT: if (advance) begin
                state_next = IDLE;
                done_next  = 1'b1;
              end
      default: state_next = IDLE;
    endcase
  end

  assign busy   = (state != IDLE);
  assign atomic = busy | (start & ~busy);
  assign ins_op = state;
  assign mwait  = pending & ~datack;
  assign mreq   = in_products | mwait;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      step      <= (CW+1)'(1);
      width_reg <= '0;
      col_reg   <= 1'b0;
      maddr     <= '0;
      pending   <= 1'b0;
      half      <= 1'b0;
      ins_src   <= '0;
      ins_dst   <= '0;
      done      <= 1'b0;
    end else begin
      state   <= state_next;
      done    <= done_next;
      pending <= mreq;

      if (cfg_wr) begin
        width_reg <= cfg_din[CW-1:0];
        col_reg   <= cfg_din[CW];
      end

      // An explicit base load wins over an acknowledge-driven stride step.
      if (base_wr)
        maddr <= base_din;
      else if (pending && datack)
        maddr <= maddr + {{(AW-CW-1){1'b0}}, step};

      if (accept) begin
        count   <= width_full;
        step    <= col_reg ? width_full : (CW+1)'(1);
        ins_src <= src_reg;
        ins_dst <= dst_reg;
        half    <= 1'b0;
      end else if (advance && in_products) begin
        count <= count - (CW+1)'(1);
        half  <= ~half;
        if (half) ins_src <= ins_src + RW'(1);
      end
    end
  end

endmodule
